// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel debouncer.
// Counter width is derived here so channel and top agree on it.
package debounce_pkg;

   localparam int DEFAULT_SYNC_STAGES   = 2;
   localparam int DEFAULT_STABLE_CYCLES = 8;

   // Counter only ever reaches stable-1, so $clog2(stable) bits suffice (min 1).
   function automatic int cnt_width(input int stable);
      int w;
      w = $clog2(stable);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/debounce_multi_if.sv
// Bundle of the debouncer's data-path signals; slave side is the debouncer,
// master side is whoever drives the raw inputs and consumes the results.
interface debounce_multi_if #(
   parameter int N_CH = 4
);
   logic            tick_i;
   logic [N_CH-1:0] data_in;
   logic [N_CH-1:0] data_out;
   logic [N_CH-1:0] rise_o;
   logic [N_CH-1:0] fall_o;
   logic            any_change_o;

   modport master (
      output tick_i, data_in,
      input  data_out, rise_o, fall_o, any_change_o
   );

   modport slave (
      input  tick_i, data_in,
      output data_out, rise_o, fall_o, any_change_o
   );
endinterface

// File: rtl/debounce_channel.sv
// One debounced channel: synchroniser chain, stability counter, edge pulses.
// change_nxt is the combinational "level accepted this edge" strobe for the top-level OR.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int   SYNC_STAGES   = DEFAULT_SYNC_STAGES,
   parameter int   STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
   parameter logic RESET_LEVEL   = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall,
   output logic change_nxt
);
   localparam int              CNT_W   = cnt_width(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic [CNT_W-1:0]       cnt;
   logic                   s;
   logic                   accept;

   assign s          = sync[SYNC_STAGES-1];
   assign accept     = (s != dout) && tick && (cnt == CNT_MAX);
   assign change_nxt = accept;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= {SYNC_STAGES{RESET_LEVEL}};
         cnt  <= '0;
         dout <= RESET_LEVEL;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], din};
         rise <= accept & s;
         fall <= accept & ~s;
         // Any agreement with the current level restarts the window, tick or not.
         if (s == dout) begin
            cnt <= '0;
         end else if (tick) begin
            if (accept) begin
               dout <= s;
               cnt  <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer top: N_CH independent channels plus a registered
// any-change flag aligned with the per-channel rise/fall pulses.
module debounce_multi
   import debounce_pkg::*;
#(
   parameter int   N_CH          = 4,
   parameter int   SYNC_STAGES   = DEFAULT_SYNC_STAGES,
   parameter int   STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
   parameter logic RESET_LEVEL   = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   debounce_multi_if.slave  bus
);
   logic [N_CH-1:0] dout;
   logic [N_CH-1:0] rise;
   logic [N_CH-1:0] fall;
   logic [N_CH-1:0] change_nxt;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_channel #(
         .SYNC_STAGES   (SYNC_STAGES),
         .STABLE_CYCLES (STABLE_CYCLES),
         .RESET_LEVEL   (RESET_LEVEL)
      ) u_ch (
         .clk        (clk),
         .rst_n      (rst_n),
         .tick       (bus.tick_i),
         .din        (bus.data_in[i]),
         .dout       (dout[i]),
         .rise       (rise[i]),
         .fall       (fall[i]),
         .change_nxt (change_nxt[i])
      );
   end

   assign bus.data_out = dout;
   assign bus.rise_o   = rise;
   assign bus.fall_o   = fall;

   // Registered from the same strobes that set the pulses, so it lands in their cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) bus.any_change_o <= 1'b0;
      else        bus.any_change_o <= |change_nxt;
   end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi at N_CH=4, SYNC_STAGES=2, STABLE_CYCLES=8.
module tb_debounce_multi;

   typedef struct {
      string      name;
      logic [3:0] din;
      logic       tick;
      int         edges;
      logic [3:0] exp_out;
      logic [3:0] exp_rise;
      logic [3:0] exp_fall;
      logic       exp_any;
   } vec_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   logic [3:0] cur_out;

   debounce_multi_if #(.N_CH(4)) bus ();

   debounce_multi #(
      .N_CH          (4),
      .SYNC_STAGES   (2),
      .STABLE_CYCLES (8),
      .RESET_LEVEL   (1'b0)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [3:0] eo, input logic [3:0] er,
                        input logic [3:0] ef, input logic ea);
      checks++;
      if ({bus.data_out, bus.rise_o, bus.fall_o, bus.any_change_o} !== {eo, er, ef, ea}) begin
         errors++;
         $display("FAIL %s @%0t: got out=%b rise=%b fall=%b any=%b, exp out=%b rise=%b fall=%b any=%b",
                  name, $time, bus.data_out, bus.rise_o, bus.fall_o, bus.any_change_o,
                  eo, er, ef, ea);
      end
   endtask

   // Apply a row; all edges but the last must be quiet at the previous level.
   task automatic run_row(input vec_t v);
      bus.data_in = v.din;
      bus.tick_i  = v.tick;
      for (int i = 0; i < v.edges; i++) begin
         step();
         if (i < v.edges - 1) check(v.name, cur_out, 4'b0, 4'b0, 1'b0);
         else                 check(v.name, v.exp_out, v.exp_rise, v.exp_fall, v.exp_any);
      end
      cur_out = v.exp_out;
   endtask

   function automatic vec_t mk(input string n, input logic [3:0] d, input logic t, input int e,
                               input logic [3:0] o, input logic [3:0] r, input logic [3:0] f,
                               input logic a);
      vec_t v;
      v.name = n; v.din = d; v.tick = t; v.edges = e;
      v.exp_out = o; v.exp_rise = r; v.exp_fall = f; v.exp_any = a;
      return v;
   endfunction

   vec_t tbl[18];

   initial begin
      checks  = 0;
      errors  = 0;
      cur_out = 4'b0;

      // Clean step, simultaneous rise/fall, and bounce sequences.
      tbl[0]  = mk("step0",       4'b0001, 1'b1, 10, 4'b0001, 4'b0001, 4'b0000, 1'b1);
      tbl[1]  = mk("step0_hold",  4'b0001, 1'b1,  1, 4'b0001, 4'b0000, 4'b0000, 1'b0);
      tbl[2]  = mk("to_0100",     4'b0100, 1'b1, 10, 4'b0100, 4'b0100, 4'b0001, 1'b1);
      tbl[3]  = mk("to_0100_hold",4'b0100, 1'b1,  1, 4'b0100, 4'b0000, 4'b0000, 1'b0);
      tbl[4]  = mk("simul",       4'b1000, 1'b1, 10, 4'b1000, 4'b1000, 4'b0100, 1'b1);
      tbl[5]  = mk("simul_hold",  4'b1000, 1'b1,  1, 4'b1000, 4'b0000, 4'b0000, 1'b0);
      tbl[6]  = mk("clear3",      4'b0000, 1'b1, 10, 4'b0000, 4'b0000, 4'b1000, 1'b1);
      tbl[7]  = mk("clear3_hold", 4'b0000, 1'b1,  1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      tbl[8]  = mk("bnc_hi3",     4'b0010, 1'b1,  3, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      tbl[9]  = mk("bnc_lo2",     4'b0000, 1'b1,  2, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      tbl[10] = mk("bnc_hi5",     4'b0010, 1'b1,  5, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      tbl[11] = mk("bnc_lo1",     4'b0000, 1'b1,  1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      tbl[12] = mk("bnc_final",   4'b0010, 1'b1, 10, 4'b0010, 4'b0010, 4'b0000, 1'b1);
      tbl[13] = mk("bnc_hold",    4'b0010, 1'b1,  1, 4'b0010, 4'b0000, 4'b0000, 1'b0);
      tbl[14] = mk("clear1",      4'b0000, 1'b1, 10, 4'b0000, 4'b0000, 4'b0010, 1'b1);
      tbl[15] = mk("clear1_hold", 4'b0000, 1'b1,  1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      tbl[16] = mk("clear2",      4'b0000, 1'b1, 10, 4'b0000, 4'b0000, 4'b0100, 1'b1);
      tbl[17] = mk("clear2_hold", 4'b0000, 1'b1,  1, 4'b0000, 4'b0000, 4'b0000, 1'b0);

      // Asynchronous reset asserted mid-cycle with all inputs high.
      rst_n       = 1'b1;
      bus.tick_i  = 1'b1;
      bus.data_in = 4'hF;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check("reset_async", 4'b0, 4'b0, 4'b0, 1'b0);
      bus.data_in = 4'h0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      run_row(mk("rst_quiet", 4'b0000, 1'b1, 20, 4'b0000, 4'b0000, 4'b0000, 1'b0));

      for (int i = 0; i < 16; i++) run_row(tbl[i]);

      // Slow tick: only edges 3,7,11,... are ticked; s mismatches from edge 2,
      // so the 8th ticked mismatch is edge 31.
      bus.data_in = 4'b0100;
      for (int e = 0; e < 32; e++) begin
         bus.tick_i = (e % 4 == 3);
         step();
         if (e < 31) check("tick_wait", 4'b0000, 4'b0, 4'b0, 1'b0);
         else        check("tick_accept", 4'b0100, 4'b0100, 4'b0000, 1'b1);
      end
      cur_out = 4'b0100;
      run_row(mk("tick_hold", 4'b0100, 1'b1, 1, 4'b0100, 4'b0000, 4'b0000, 1'b0));
      run_row(tbl[16]);
      run_row(tbl[17]);

      // Reset mid-count on channel 3 (cnt=5 after edge 6), release with input still high.
      bus.data_in = 4'b1000;
      bus.tick_i  = 1'b1;
      for (int e = 0; e < 7; e++) begin
         step();
         check("mid_count", 4'b0000, 4'b0, 4'b0, 1'b0);
      end
      #2 rst_n = 1'b0;
      #1 check("reset_mid", 4'b0, 4'b0, 4'b0, 1'b0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      cur_out = 4'b0000;
      run_row(mk("rst_mid_rel",  4'b1000, 1'b1, 10, 4'b1000, 4'b1000, 4'b0000, 1'b1));
      run_row(mk("rst_mid_hold", 4'b1000, 1'b1,  1, 4'b1000, 4'b0000, 4'b0000, 1'b0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
